// File: rtl/ps_div_pkg.sv
// Shared definitions for the pulse-swallow divider control block:
// the default minimum P and the S clamp / P legality helpers.
package ps_div_pkg;

    // Smallest P the divider accepts by default (must be >= 2).
    localparam int P_MIN_DEF = 2;

    // Result of clamping a requested S against a requested P.
    typedef struct packed {
        logic [31:0] s;    // S after clamping (to be truncated to S_WIDTH)
        logic        err;  // 1 when the requested S had to be clamped
    } clamp_t;

    // S must stay strictly below P; otherwise it is pinned to P-1.
    // Arguments are zero-extended, so the compare is unsigned.
    function automatic clamp_t clamp_s(input logic [31:0] pi, input logic [31:0] si);
        clamp_t r;
        if (si >= pi) begin
            r.s   = pi - 32'd1;
            r.err = 1'b1;
        end else begin
            r.s   = si;
            r.err = 1'b0;
        end
        return r;
    endfunction

    // A requested P is usable only if it is at least p_min.
    function automatic logic legal_p(input logic [31:0] pi, input logic [31:0] p_min);
        return (pi >= p_min);
    endfunction

endpackage

// File: rtl/ps_div_ctrl_s_swallow_cnt.sv
// Swallow (S) down-counter. Reloads at the load strobe and counts down
// to zero; MCo selects the M+1 prescaler modulus while it is non-zero.
module s_swallow_cnt #(
    parameter int S_WIDTH = 3
) (
    input  logic               Fin,
    input  logic               rst_n,
    input  logic               LDi,
    input  logic [S_WIDTH-1:0] s_new,
    output logic               MCo
);

    logic [S_WIDTH-1:0] scnt_q;

    // Reload on the load strobe, otherwise count down and park at zero.
    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q <= '0;
        end else if (LDi) begin
            scnt_q <= s_new;
        end else if (scnt_q != '0) begin
            scnt_q <= scnt_q - S_WIDTH'(1);
        end
    end

    assign MCo = (scnt_q != '0);

endmodule

// File: rtl/ps_div_ctrl.sv
// Program/swallow counter pair for a dual-modulus pulse-swallow divider
// with double-buffered P/S reprogramming, S clamping, P rejection and a
// near-50% duty divided output.
//
// Update handshake: the requester drives Pi/Si and holds upd_req high with
// Pi/Si stable. The request is consumed only on an edge where LDo=1, which
// makes the change land exactly on the period boundary. upd_ack pulses for
// the single cycle after that edge; the requester drops upd_req when it sees
// it. A request still high at a later LDo is simply applied and acked again.
module ps_div_ctrl
    import ps_div_pkg::*;
#(
    parameter int P_WIDTH = 5,
    parameter int S_WIDTH = 3,
    parameter int P_MIN   = P_MIN_DEF
) (
    input  logic               Fin,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] Pi,
    input  logic [S_WIDTH-1:0] Si,
    input  logic               upd_req,
    output logic               upd_ack,
    output logic               LDo,
    output logic               MCo,
    output logic               Fout,
    output logic               cfg_err,
    output logic [P_WIDTH-1:0] p_cnt
);

    logic [P_WIDTH-1:0] p_act_q, p_act_d;
    logic [S_WIDTH-1:0] s_act_q, s_act_d;
    logic [P_WIDTH-1:0] pcnt_q;
    logic               upd_ack_q;
    logic               cfg_err_q, cfg_err_d;

    logic               ld;
    logic               apply;
    logic               p_ok;
    clamp_t             clamp;

    // Load boundary is decoded from the P counter alone.
    assign ld    = (pcnt_q == '0);
    assign apply = ld & upd_req;

    assign p_ok  = legal_p(32'(Pi), 32'(P_MIN));
    assign clamp = clamp_s(32'(Pi), 32'(Si));

    // Next configuration: the requested values on an applied, legal update,
    // otherwise the active ones (a rejected request only raises cfg_err).
    always_comb begin
        p_act_d   = p_act_q;
        s_act_d   = s_act_q;
        cfg_err_d = cfg_err_q;
        if (apply) begin
            if (p_ok) begin
                p_act_d   = Pi;
                s_act_d   = S_WIDTH'(clamp.s);
                cfg_err_d = clamp.err;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Configuration, handshake and P counter; the P counter reloads from the
    // configuration that takes effect at this same edge.
    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) begin
            p_act_q   <= P_WIDTH'(P_MIN);
            s_act_q   <= '0;
            pcnt_q    <= '0;
            upd_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            p_act_q   <= p_act_d;
            s_act_q   <= s_act_d;
            cfg_err_q <= cfg_err_d;
            upd_ack_q <= apply;
            if (ld) begin
                pcnt_q <= p_act_d - P_WIDTH'(1);
            end else begin
                pcnt_q <= pcnt_q - P_WIDTH'(1);
            end
        end
    end

    s_swallow_cnt #(
        .S_WIDTH (S_WIDTH)
    ) u_s_cnt (
        .Fin   (Fin),
        .rst_n (rst_n),
        .LDi   (ld),
        .s_new (s_act_d),
        .MCo   (MCo)
    );

    // Output high from P-1 down to floor(P/2): ceil(P/2) cycles after LDo.
    assign Fout    = (pcnt_q >= (p_act_q >> 1));
    assign LDo     = ld;
    assign upd_ack = upd_ack_q;
    assign cfg_err = cfg_err_q;
    assign p_cnt   = pcnt_q;

endmodule

// File: tb/tb_ps_div_ctrl.sv
// Self-checking bench for ps_div_ctrl: a phase-based reference model pushes
// the expected output vector for every cycle, and a monitor compares it with
// the DUT on the falling edge.
module tb_ps_div_ctrl;

  localparam int PW = 5;
  localparam int SW = 3;
  localparam int PMIN = 2;
  localparam int VW = PW + 5;

  logic          Fin = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] Pi = '0;
  logic [SW-1:0] Si = '0;
  logic          upd_req = 1'b0;
  logic          upd_ack;
  logic          LDo;
  logic          MCo;
  logic          Fout;
  logic          cfg_err;
  logic [PW-1:0] p_cnt;

  int total = 0;
  int bad = 0;

  logic [VW-1:0] exp_q[$];

  ps_div_ctrl dut (
    .Fin     (Fin),
    .rst_n   (rst_n),
    .Pi      (Pi),
    .Si      (Si),
    .upd_req (upd_req),
    .upd_ack (upd_ack),
    .LDo     (LDo),
    .MCo     (MCo),
    .Fout    (Fout),
    .cfg_err (cfg_err),
    .p_cnt   (p_cnt)
  );

  // clock
  always #5 Fin = ~Fin;

  function automatic void check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual{ld,mc,fo,ack,err,pcnt}=%b_%b_%b_%b_%b_%0d required=%b_%b_%b_%b_%b_%0d",
               name, $time, act[VW-1], act[VW-2], act[VW-3], act[VW-4], act[VW-5], act[PW-1:0],
               exp[VW-1], exp[VW-2], exp[VW-3], exp[VW-4], exp[VW-5], exp[PW-1:0]);
    end
  endfunction

  function automatic void fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s t=%0t actual=timeout required=event", name, $time);
  endfunction

  // Reference model: k is the cycle index inside the current period
  // (0 = load cycle), p/s the active configuration.
  int m_k = 0, m_p = PMIN, m_s = 0;
  bit m_ack = 0, m_err = 0;

  function automatic logic [VW-1:0] expect_vec(input int k, input int p, input int s, input bit ack, input bit err);
    logic ld, mc, fo;
    int pc;
    ld = (k == 0);
    mc = (k >= 1) && (k <= s);
    fo = (k >= 1) && (k <= (p + 1) / 2);
    pc = (k == 0) ? 0 : p - k;
    return {ld, mc, fo, ack, err, PW'(pc)};
  endfunction

  always @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_p = PMIN; m_s = 0; m_ack = 0; m_err = 0;
      exp_q.delete();
    end else begin
      if (m_k == 0) begin
        m_ack = upd_req;
        if (upd_req) begin
          if (int'(Pi) < PMIN) begin
            m_err = 1;
          end else begin
            m_p = int'(Pi);
            if (int'(Si) >= int'(Pi)) begin
              m_s = int'(Pi) - 1;
              m_err = 1;
            end else begin
              m_s = int'(Si);
              m_err = 0;
            end
          end
        end
        m_k = 1;
      end else begin
        m_ack = 0;
        m_k = (m_k + 1 == m_p) ? 0 : m_k + 1;
      end
      exp_q.push_back(expect_vec(m_k, m_p, m_s, m_ack, m_err));
    end
  end

  // Monitor: reset values while in reset, scoreboard otherwise.
  always @(negedge Fin or negedge rst_n) begin
    logic [VW-1:0] act;
    if (!rst_n) begin
      #1;
      act = {LDo, MCo, Fout, upd_ack, cfg_err, p_cnt};
      check("reset_state", act, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW'(0)});
    end else if (exp_q.size() == 0) begin
      fail_event("no_expectation");
    end else begin
      act = {LDo, MCo, Fout, upd_ack, cfg_err, p_cnt};
      check("cycle", act, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge Fin);
  endtask

  task automatic wait_ack(input int hold);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Fin);
      if (upd_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_event("ack_timeout");
    repeat (hold) @(negedge Fin);
    upd_req = 1'b0;
  endtask

  task automatic request(input int p, input int s, input int hold);
    @(negedge Fin);
    Pi = PW'(p);
    Si = SW'(s);
    upd_req = 1'b1;
    wait_ack(hold);
  endtask

  task automatic wait_ldo();
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Fin);
      if (LDo) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_event("ldo_timeout");
  endtask

  initial begin
    bit got;
    // startup programming: request held through reset release
    Pi = PW'(7); Si = SW'(3); upd_req = 1'b1;
    run(3);
    #2 rst_n = 1'b1;
    wait_ack(0);
    run(20);

    // mid-period update
    wait_ldo();
    run(3);
    request(10, 2, 0);
    run(25);

    // clamp
    request(5, 7, 0);
    run(15);

    // reject, then a legal request clears the error
    request(7, 3, 0);
    run(10);
    request(1, 0, 0);
    run(20);
    request(6, 1, 0);
    run(15);

    // reset mid-count
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Fin);
      if (p_cnt == PW'(4)) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_event("pcnt4_timeout");
    #2 rst_n = 1'b0;
    run(2);
    #2 rst_n = 1'b1;
    run(10);

    // extremes
    request(31, 7, 0);
    run(70);

    // random requests, sometimes held long enough to be re-applied
    for (int n = 0; n < 30; n++) begin
      run($urandom_range(0, 20));
      request($urandom_range(0, 31), $urandom_range(0, 7),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 0);
    end
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps_div_ctrl.md
Name: ps_div_ctrl

Overview:
- Parametrised successor of the P/S counter pair for the dual-modulus pulse-swallow divider.
- One block holds the program counter (P) and the swallow counter (S).
- Adds double-buffered P/S reprogramming through a req/ack handshake. New values take effect only at the load boundary, so reprogramming is glitch-free.
- Adds S≥P clamping, P<P_MIN rejection, and a ~50% duty Fout.
- Sits after the dual-modulus prescaler: Fin is the prescaler output and MCo drives the prescaler modulus select.

Parameters:
P_WIDTH  5  width of Pi, P counter, p_cnt
S_WIDTH  3  width of Si, S counter
P_MIN    2  smallest legal P, must be ≥2

Ports:
Fin      in   1        clock (prescaler output), rising edge
rst_n    in   1        reset, asynchronous, active-low
Pi       in   P_WIDTH  requested P; held stable while upd_req=1
Si       in   S_WIDTH  requested S; held stable while upd_req=1
upd_req  in   1        level request to apply Pi/Si at next load
upd_ack  out  1        1-cycle pulse: request consumed
LDo      out  1        load strobe; high in the terminal cycle of P
MCo      out  1        modulus control; 1 selects M+1
Fout     out  1        divided output, period p_act Fin cycles
cfg_err  out  1        last applied request was clamped or rejected
p_cnt    out  P_WIDTH  current P counter value (debug)

Behaviour:
- State registers:
  - p_act, s_act: active configuration.
  - pcnt: P down-counter.
  - scnt: S down-counter.
  - Registered outputs: upd_ack, cfg_err.
- Reset values (applied asynchronously, including mid-operation): p_act=P_MIN, s_act=0, pcnt=0, scnt=0, upd_ack=0, cfg_err=0.
  - Consequence: LDo=1 in the first cycle after reset, MCo=0, Fout=0.
- LDo = (pcnt==0). Decoded from registers only; no combinational path from any input.
- P counter:
  - If pcnt==0, load pcnt with (p_new−1) at the edge; otherwise decrement.
  - p_new = applied Pi if an update is applied at this edge, else p_act.
  - Result: period = p_act cycles, with LDo high exactly 1 cycle per period.
- S counter:
  - When LDo=1, load scnt with s_new at the edge.
  - Otherwise decrement scnt if scnt≠0, or hold it at 0.
  - MCo = (scnt≠0), so MCo is high for exactly s_act cycles starting the cycle after LDo.
- Fout = (pcnt ≥ floor(p_act/2)), decoded from registers.
  - High for ceil(P/2) cycles starting the cycle after LDo, then low for floor(P/2).
  - Example: P=7 gives 4 high / 3 low.
- Update rule: an update applies only on an edge where LDo=1 and upd_req=1.
  - Pi<P_MIN: reject. p_act and s_act are unchanged, cfg_err<=1, upd_ack<=1.
  - Else if Si ≥ Pi: p_act<=Pi, s_act<=Pi−1 (clamped), cfg_err<=1, upd_ack<=1.
  - Else: p_act<=Pi, s_act<=Si, cfg_err<=0, upd_ack<=1.
  - The applied values govern the reload at that same edge (pcnt<=Pi−1, scnt<=s_new). Rejected requests reload from the old values.
- upd_ack:
  - High during the one cycle following the apply edge; 0 otherwise.
  - The requester drops upd_req on seeing ack.
  - If upd_req is still high at a later LDo, it is re-applied (idempotent) and re-acked.
- upd_req asserted while LDo=1: it is taken at that same edge.
- upd_req held high through reset release: Pi/Si are applied at the first edge after reset. This is the startup programming path.
- cfg_err is sticky until the next applied request.
- Arithmetic:
  - All compares are unsigned.
  - Si is zero-extended to max(P_WIDTH,S_WIDTH) for the Si≥Pi compare.
  - The clamp result is truncated to S_WIDTH. If P−1 exceeds 2^S_WIDTH−1, clamping never occurs.
- Invariants:
  - MCo is always 0 in the LDo cycle, because S≤P−1.
  - The counters never wrap below 0.

Decomposition:
- Package ps_div_pkg:
  - P_MIN default.
  - Function clamp_s(Pi,Si) returning the clamped S and an error flag.
  - Function legal_p(Pi).
- One sub-module, s_swallow_cnt.
  - Ports: Fin, rst_n, LDi, s_new → MCo.
  - Parameter: S_WIDTH.
- The top level holds the P counter, configuration registers, handshake and Fout decode.

Test Plan:
- Startup programming: hold upd_req=1 with Pi=7, Si=3 through reset release.
  - Expect upd_ack in cycle 2.
  - Then LDo every 7 cycles, MCo high the 3 cycles after each LDo.
  - Fout pattern 1111000.
- Mid-period update: raise upd_req with Pi=10, Si=2 three cycles after an LDo.
  - The current 7-cycle period completes unchanged.
  - upd_ack is high the cycle after the next LDo.
  - The following period is 10 cycles with MCo high for 2 cycles and Fout 5 high / 5 low.
- Clamp: Pi=5, Si=7.
  - Expect s_act=4: MCo high for 4 cycles, low in the LDo cycle.
  - cfg_err=1, period 5.
- Reject: Pi=1, Si=0 while running at P=7, S=3.
  - upd_ack pulses, cfg_err=1, period stays 7 with MCo=3.
  - A subsequent legal request (Pi=6, Si=1) clears cfg_err.
- Reset mid-count: assert rst_n=0 at pcnt=4.
  - LDo=1, MCo=0, Fout=0, upd_ack=0 immediately.
  - With upd_req=0 after release: period 2 (P_MIN), MCo never high.
- Extremes: Pi=31, Si=7.
  - Period 31, MCo high 7 cycles, Fout 16 high / 15 low.
  - p_cnt sequence 30→0 with no wrap.
